// File: rtl/sparc_exu_ecl_divseq_if.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_ecl_divseq_if
// Description : Request, datapath-strobe and completion bundle of the
//               iterative-divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sparc_exu_ecl_divseq_if;
    logic       div_req_vld;
    logic       div_req_rdy;
    logic       div_req_signed;
    logic       div_req_64b;
    logic [1:0] div_req_tid;
    logic       divisor_zero;
    logic       dividend_zero;
    logic       div_kill;
    logic       ecl_div_load;
    logic       ecl_div_shift;
    logic       ecl_div_last;
    logic       ecl_div_fix;
    logic [5:0] div_cnt;
    logic       div_done_vld;
    logic       div_done_rdy;
    logic [1:0] div_done_tid;
    logic       div_done_dz;
    logic       div_done_zq;

    // Issue / writeback side
    modport master (
        output div_req_vld, div_req_signed, div_req_64b, div_req_tid,
               divisor_zero, dividend_zero, div_kill, div_done_rdy,
        input  div_req_rdy, ecl_div_load, ecl_div_shift, ecl_div_last,
               ecl_div_fix, div_cnt, div_done_vld, div_done_tid,
               div_done_dz, div_done_zq
    );

    // Sequencer side
    modport slave (
        input  div_req_vld, div_req_signed, div_req_64b, div_req_tid,
               divisor_zero, dividend_zero, div_kill, div_done_rdy,
        output div_req_rdy, ecl_div_load, ecl_div_shift, ecl_div_last,
               ecl_div_fix, div_cnt, div_done_vld, div_done_tid,
               div_done_dz, div_done_zq
    );
endinterface
`default_nettype wire

// File: rtl/sparc_exu_ecl_divseq.sv
`default_nettype none
// ============================================================================
// Module      : sparc_exu_ecl_divseq
// Description : Iterative-divide sequencer: accepts one divide, steps the
//               shift-subtract datapath and returns a completion with tid/dz.
//               Optional macro EXU_DIVSEQ_ZERO_EARLY_EN enables the
//               zero-dividend short-cut.
// Revision    : 1.0 - initial release
// ============================================================================
module sparc_exu_ecl_divseq (
    input  logic                         clk,
    input  logic                         arst_l,
    input  logic                         se,
    sparc_exu_ecl_divseq_if.slave        bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] cnt;
    logic [5:0] cnt_nxt;
    logic       signed_q;
    logic       b64_q;
    logic       dz_q;
    logic       dvz_q;
    logic [1:0] tid_q;
    logic       accept;
    logic       zero_early;
    logic       unused_ok;

    // Ready is held low while reset is asserted so the whole output set reads 0.
    assign bus.div_req_rdy = arst_l & (state == IDLE) & ~bus.div_kill;
    assign accept          = bus.div_req_vld & bus.div_req_rdy;

`ifdef EXU_DIVSEQ_ZERO_EARLY_EN
    assign zero_early = dvz_q & ~dz_q;
    assign unused_ok  = se;
`else
    assign zero_early = 1'b0;
    assign unused_ok  = se ^ dvz_q;
`endif

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            signed_q <= 1'b0;
            b64_q    <= 1'b0;
            dz_q     <= 1'b0;
            dvz_q    <= 1'b0;
            tid_q    <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                signed_q <= bus.div_req_signed;
                b64_q    <= bus.div_req_64b;
                dz_q     <= bus.divisor_zero;
                dvz_q    <= bus.dividend_zero;
                tid_q    <= bus.div_req_tid;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 6'd0;
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                if (dz_q | zero_early) begin
                    state_nxt = DONE;
                end else begin
                    // 32-bit divides start half-way so both widths end at 63.
                    cnt_nxt   = b64_q ? 6'd0 : 6'd32;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd63) state_nxt = signed_q ? FIX : DONE;
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.div_done_rdy) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 6'd0;
            end
        endcase
        if ((state != IDLE) && bus.div_kill) begin
            state_nxt = IDLE;
            cnt_nxt   = 6'd0;
        end
    end

    assign bus.ecl_div_load  = (state == LOAD);
    assign bus.ecl_div_shift = (state == RUN);
    assign bus.ecl_div_last  = (state == RUN) && (cnt == 6'd63);
    assign bus.ecl_div_fix   = (state == FIX);
    assign bus.div_cnt       = cnt;
    assign bus.div_done_vld  = (state == DONE);
    assign bus.div_done_tid  = (state == DONE) ? tid_q : 2'd0;
    assign bus.div_done_dz   = (state == DONE) & dz_q;
    assign bus.div_done_zq   = (state == DONE) & zero_early;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_ecl_divseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparc_exu_ecl_divseq
// Description : Directed self-checking bench for the divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparc_exu_ecl_divseq;

    logic clk;
    logic arst_l;
    logic se;
    int   tests;
    int   fails;

    sparc_exu_ecl_divseq_if bus ();

    sparc_exu_ecl_divseq dut (
        .clk    (clk),
        .arst_l (arst_l),
        .se     (se),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {load, shift, last, fix, cnt[5:0], vld, tid[1:0], dz, zq, req_rdy}
    function automatic logic [15:0] obs();
        return {bus.ecl_div_load, bus.ecl_div_shift, bus.ecl_div_last,
                bus.ecl_div_fix, bus.div_cnt, bus.div_done_vld,
                bus.div_done_tid, bus.div_done_dz, bus.div_done_zq,
                bus.div_req_rdy};
    endfunction

    // Expected outputs k cycles after acceptance, done_rdy held high.
    function automatic logic [15:0] exp_vec(int k, bit sgn, bit b64, bit dz,
                                            bit zq, logic [1:0] tid);
        int         start;
        int         lastk;
        int         donek;
        logic       shift;
        logic       vld;
        logic [5:0] c;
        start = b64 ? 0 : 32;
        lastk = -10;
        donek = 2;
        if (!(dz || zq)) begin
            lastk = 1 + 64 - start;
            donek = lastk + 1 + (sgn ? 1 : 0);
        end
        shift = !(dz || zq) && (k >= 2) && (k <= lastk);
        c     = shift ? 6'(start + k - 2) : 6'd0;
        vld   = (k == donek);
        return {(k == 1), shift, shift && (k == lastk),
                !(dz || zq) && sgn && (k == lastk + 1), c, vld,
                vld ? tid : 2'b00, vld & dz, vld & zq, (k > donek)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(bit sgn, bit b64, bit dz, bit dvz, logic [1:0] tid);
        bus.div_req_signed = sgn;
        bus.div_req_64b    = b64;
        bus.divisor_zero   = dz;
        bus.dividend_zero  = dvz;
        bus.div_req_tid    = tid;
        bus.div_req_vld    = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] act;
        #3;
        act = obs();
        tests++;
        if (act !== 16'h0000) begin
            fails++;
            $display("FAIL reset_hold got %h want %h", act, 16'h0000);
        end
        tick();
        tick();
        arst_l = 1'b1;
        #1;
        act = obs();
        tests++;
        if (act !== 16'h0001) begin
            fails++;
            $display("FAIL reset_release got %h want %h", act, 16'h0001);
        end
    endtask

    task automatic test_unsigned64();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL u64 k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_signed32();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        for (int k = 1; k <= 37; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL s32 k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_div_zero_hold();
        logic [15:0] act;
        bus.div_done_rdy = 1'b0;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
        tick();
        bus.div_req_vld = 1'b0;
        act = obs();
        tests++;
        if (act !== 16'h8000) begin
            fails++;
            $display("FAIL dz_load got %h want %h", act, 16'h8000);
        end
        for (int k = 2; k <= 6; k++) begin
            tick();
            act = obs();
            tests++;
            if (act !== 16'h003C) begin
                fails++;
                $display("FAIL dz_hold k=%0d got %h want %h", k, act, 16'h003C);
            end
        end
        bus.div_done_rdy = 1'b1;
        tick();
        act = obs();
        tests++;
        if (act !== 16'h0001) begin
            fails++;
            $display("FAIL dz_release got %h want %h", act, 16'h0001);
        end
    endtask

    task automatic test_kill_run();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL kill_pre k=%0d got %h want %h", k, act, exp);
            end
        end
        bus.div_kill = 1'b1;
        tick();
        bus.div_kill = 1'b0;
        #1;
        act = obs();
        tests++;
        if (act !== 16'h0001) begin
            fails++;
            $display("FAIL kill_idle got %h want %h", act, 16'h0001);
        end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL kill_post k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_kill_idle();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        bus.div_kill = 1'b1;
        #1;
        act = obs();
        tests++;
        if (act !== 16'h0000) begin
            fails++;
            $display("FAIL kill_block_rdy got %h want %h", act, 16'h0000);
        end
        tick();
        act = obs();
        tests++;
        if (act !== 16'h0000) begin
            fails++;
            $display("FAIL kill_block_noload got %h want %h", act, 16'h0000);
        end
        bus.div_kill = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL kill_block_run k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
        end
        #2;
        arst_l = 1'b0;
        #1;
        act = obs();
        tests++;
        if (act !== 16'h0000) begin
            fails++;
            $display("FAIL arst_now got %h want %h", act, 16'h0000);
        end
        tick();
        arst_l = 1'b1;
        #1;
        act = obs();
        tests++;
        if (act !== 16'h0001) begin
            fails++;
            $display("FAIL arst_release got %h want %h", act, 16'h0001);
        end
        issue(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 67; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL arst_fresh k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] act;
        logic [15:0] exp;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL b2b_first k=%0d got %h want %h", k, act, exp);
            end
        end
        issue(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        for (int k = 1; k <= 69; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL b2b_second k=%0d got %h want %h", k, act, exp);
            end
        end
    endtask

    task automatic test_dividend_zero();
        logic [15:0] act;
        logic [15:0] exp;
        bit          zq;
`ifdef EXU_DIVSEQ_ZERO_EARLY_EN
        zq = 1'b1;
`else
        zq = 1'b0;
`endif
        issue(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (k == 1) bus.div_req_vld = 1'b0;
            act = obs();
            exp = exp_vec(k, 1'b0, 1'b1, 1'b0, zq, 2'd1);
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL dvz k=%0d got %h want %h", k, act, exp);
            end
        end
        bus.dividend_zero = 1'b0;
    endtask

    initial begin
        tests              = 0;
        fails              = 0;
        arst_l             = 1'b0;
        se                 = 1'b0;
        bus.div_req_vld    = 1'b0;
        bus.div_req_signed = 1'b0;
        bus.div_req_64b    = 1'b0;
        bus.div_req_tid    = 2'd0;
        bus.divisor_zero   = 1'b0;
        bus.dividend_zero  = 1'b0;
        bus.div_kill       = 1'b0;
        bus.div_done_rdy   = 1'b1;

        test_reset();
        test_unsigned64();
        test_signed32();
        test_div_zero_hold();
        test_kill_run();
        test_kill_idle();
        test_async_reset();
        test_back_to_back();
        test_dividend_zero();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
